// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - reaction-game session sequencer: foreperiod, GO cue, timing, fouls, best time
module reaction_round_ctrl #(
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 12,
    parameter int MAX_RT_MS   = 9999,
    parameter int ROUNDS      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic        btn_start,
    input  logic        btn_react,
    input  logic [13:0] rand_value,
    output logic [13:0] number,
    output logic [1:0]  mode,
    output logic [15:0] led,
    output logic        session_done
);

    localparam logic [13:0] MAX_RT    = 14'(MAX_RT_MS);
    localparam logic [13:0] MIN_WAIT  = 14'(MIN_WAIT_MS);
    localparam logic [13:0] RAND_MASK = 14'((1 << RAND_BITS) - 1);
    localparam logic [3:0]  ROUNDS_N  = 4'(ROUNDS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_GO      = 3'd2;
    localparam logic [2:0] S_RESULT  = 3'd3;
    localparam logic [2:0] S_FOUL    = 3'd4;
    localparam logic [2:0] S_TIMEOUT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]  state;
    logic [13:0] wait_cnt;
    logic [13:0] rt;
    logic [13:0] best;
    logic [3:0]  rounds;
    logic        start_q;
    logic        react_q;
    logic        start_press;
    logic        react_press;
    logic [13:0] foreperiod;

    logic [13:0] number_next;
    logic [1:0]  mode_next;
    logic [15:0] led_next;

    assign start_press = btn_start & ~start_q;
    assign react_press = btn_react & ~react_q;
    assign foreperiod  = MIN_WAIT + (rand_value & RAND_MASK);

    // Button history; reset to 1 so a button held through reset release never looks like a fresh press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b1;
            react_q <= 1'b1;
        end else begin
            start_q <= btn_start;
            react_q <= btn_react;
        end
    end

    // Session FSM with foreperiod countdown, reaction counter and best-time record
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            rt       <= '0;
            best     <= MAX_RT;
            rounds   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_press) begin
                        wait_cnt <= foreperiod;
                        rounds   <= '0;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    // A press coinciding with the final tick is still a false start
                    if (react_press) begin
                        state <= S_FOUL;
                    end else if (tick_1ms) begin
                        // <=1 also covers a zero foreperiod: GO on the next tick
                        if (wait_cnt <= 14'd1) begin
                            rt    <= '0;
                            state <= S_GO;
                        end else begin
                            wait_cnt <= wait_cnt - 14'd1;
                        end
                    end
                end
                S_GO: begin
                    // The press wins over a simultaneous tick, so rt is captured un-incremented
                    if (react_press) begin
                        if (rt < best) begin
                            best <= rt;
                        end
                        rounds <= rounds + 4'd1;
                        state  <= S_RESULT;
                    end else if (tick_1ms) begin
                        if (rt >= MAX_RT - 14'd1) begin
                            rt    <= MAX_RT;
                            state <= S_TIMEOUT;
                        end else begin
                            rt <= rt + 14'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (start_press) begin
                        if (rounds == ROUNDS_N) begin
                            state <= S_DONE;
                        end else begin
                            wait_cnt <= foreperiod;
                            state    <= S_ARM;
                        end
                    end
                end
                S_FOUL, S_TIMEOUT: begin
                    if (start_press) begin
                        wait_cnt <= foreperiod;
                        state    <= S_ARM;
                    end
                end
                S_DONE: begin
                    if (start_press) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Display and LED values derived from the current state
    always_comb begin
        number_next = number;
        mode_next   = 2'd0;
        led_next    = '0;
        case (state)
            S_IDLE, S_DONE: begin
                number_next = best;
                mode_next   = 2'd0;
            end
            S_ARM, S_GO: begin
                mode_next = 2'd1;
            end
            S_RESULT: begin
                number_next = rt;
                mode_next   = 2'd2;
            end
            S_FOUL, S_TIMEOUT: begin
                number_next = MAX_RT;
                mode_next   = 2'd3;
            end
            default: begin
                mode_next = 2'd0;
            end
        endcase
        for (int i = 0; i < 14; i++) begin
            if (i < ROUNDS) begin
                led_next[i] = (rounds > 4'(i));
            end
        end
        led_next[15] = (state == S_GO);
        led_next[14] = (state == S_FOUL) || (state == S_TIMEOUT);
    end

    // Output registers, one cycle behind the state they reflect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            number       <= MAX_RT;
            mode         <= 2'd0;
            led          <= '0;
            session_done <= 1'b0;
        end else begin
            number       <= number_next;
            mode         <= mode_next;
            led          <= led_next;
            session_done <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - directed self-checking bench for reaction_round_ctrl
module tb_reaction_round_ctrl;

    logic        clk;
    logic        rst;
    logic        tick_1ms;
    logic        btn_start;
    logic        btn_react;
    logic [13:0] rand_value;
    logic [13:0] number;
    logic [1:0]  mode;
    logic [15:0] led;
    logic        session_done;

    int checks;
    int errors;

    reaction_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1ms     (tick_1ms),
        .btn_start    (btn_start),
        .btn_react    (btn_react),
        .rand_value   (rand_value),
        .number       (number),
        .mode         (mode),
        .led          (led),
        .session_done (session_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs applied at negedge, outputs observable 1 time unit after posedge
    task automatic cyc(input logic t, input logic s, input logic r);
        @(negedge clk);
        tick_1ms  = t;
        btn_start = s;
        btn_react = r;
        @(posedge clk);
        #1;
    endtask

    // Start press, 1100 ms foreperiod, rt_ticks in GO, then react
    task automatic run_round(input int rt_ticks);
        cyc(0, 1, 0);
        repeat (1100) cyc(1, 0, 0);
        repeat (rt_ticks) cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        btn_start = 1'b1;
        btn_react = 1'b0;
        tick_1ms  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (number !== 14'd9999) begin errors++; $display("FAIL reset_number got %0d exp 9999", number); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode); end
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL reset_led got %h exp 0000", led); end
        checks++; if (session_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", session_done); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cyc(0, 1, 0);
        repeat (2) cyc(0, 0, 0);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL held_start_mode got %0d exp 0", mode); end
    endtask

    task automatic test_idle_react;
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL idle_react_mode got %0d exp 0", mode); end
        checks++; if (number !== 14'd9999) begin errors++; $display("FAIL idle_react_number got %0d exp 9999", number); end
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL idle_react_led got %h exp 0000", led); end
    endtask

    task automatic test_normal_round;
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL arm_mode got %0d exp 1", mode); end
        repeat (1099) cyc(1, 0, 0);
        cyc(0, 0, 0);
        checks++; if (led[15] !== 1'b0) begin errors++; $display("FAIL go_early got %b exp 0", led[15]); end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        checks++; if (led[15] !== 1'b1) begin errors++; $display("FAIL go_at_1100 got %b exp 1", led[15]); end
        repeat (250) cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        checks++; if (number !== 14'd250) begin errors++; $display("FAIL result_number got %0d exp 250", number); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL result_mode got %0d exp 2", mode); end
        checks++; if (led !== 16'h0001) begin errors++; $display("FAIL result_led got %h exp 0001", led); end
    endtask

    task automatic test_false_start;
        cyc(0, 1, 0);
        repeat (500) cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL foul_mode got %0d exp 3", mode); end
        checks++; if (number !== 14'd9999) begin errors++; $display("FAIL foul_number got %0d exp 9999", number); end
        checks++; if (led !== 16'h4001) begin errors++; $display("FAIL foul_led got %h exp 4001", led); end
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL foul_retry_mode got %0d exp 1", mode); end
        checks++; if (led !== 16'h0001) begin errors++; $display("FAIL foul_retry_led got %h exp 0001", led); end
    endtask

    task automatic test_tie_arm;
        repeat (1099) cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL tie_arm_mode got %0d exp 3", mode); end
        checks++; if (led !== 16'h4001) begin errors++; $display("FAIL tie_arm_led got %h exp 4001", led); end
    endtask

    task automatic test_tie_go;
        cyc(0, 1, 0);
        repeat (1100) cyc(1, 0, 0);
        repeat (300) cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        checks++; if (number !== 14'd300) begin errors++; $display("FAIL tie_go_number got %0d exp 300", number); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL tie_go_mode got %0d exp 2", mode); end
        checks++; if (led !== 16'h0003) begin errors++; $display("FAIL tie_go_led got %h exp 0003", led); end
    endtask

    task automatic test_timeout;
        cyc(0, 1, 0);
        repeat (1100) cyc(1, 0, 0);
        repeat (9998) cyc(1, 0, 0);
        cyc(0, 0, 0);
        checks++; if (led[15] !== 1'b1) begin errors++; $display("FAIL timeout_early got %b exp 1", led[15]); end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL timeout_mode got %0d exp 3", mode); end
        checks++; if (number !== 14'd9999) begin errors++; $display("FAIL timeout_number got %0d exp 9999", number); end
        checks++; if (led !== 16'h4003) begin errors++; $display("FAIL timeout_led got %h exp 4003", led); end
    endtask

    task automatic test_reset_mid_round;
        cyc(0, 1, 0);
        repeat (10) cyc(1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL midreset_mode got %0d exp 0", mode); end
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL midreset_led got %h exp 0000", led); end
        checks++; if (number !== 14'd9999) begin errors++; $display("FAIL midreset_number got %0d exp 9999", number); end
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        checks++; if (number !== 14'd9999) begin errors++; $display("FAIL midreset_best got %0d exp 9999", number); end
    endtask

    task automatic test_full_session;
        run_round(320);
        checks++; if (number !== 14'd320) begin errors++; $display("FAIL session_r1 got %0d exp 320", number); end
        run_round(280);
        checks++; if (number !== 14'd280) begin errors++; $display("FAIL session_r2 got %0d exp 280", number); end
        run_round(280);
        checks++; if (number !== 14'd280) begin errors++; $display("FAIL session_r3 got %0d exp 280", number); end
        run_round(400);
        checks++; if (number !== 14'd400) begin errors++; $display("FAIL session_r4 got %0d exp 400", number); end
        checks++; if (led !== 16'h000F) begin errors++; $display("FAIL session_r4_led got %h exp 000f", led); end
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        checks++; if (session_done !== 1'b1) begin errors++; $display("FAIL done_flag got %b exp 1", session_done); end
        checks++; if (number !== 14'd280) begin errors++; $display("FAIL done_best got %0d exp 280", number); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL done_mode got %0d exp 0", mode); end
        checks++; if (led[3:0] !== 4'b1111) begin errors++; $display("FAIL done_led got %b exp 1111", led[3:0]); end
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        checks++; if (session_done !== 1'b0) begin errors++; $display("FAIL idle_again_flag got %b exp 0", session_done); end
        checks++; if (number !== 14'd280) begin errors++; $display("FAIL idle_again_best got %0d exp 280", number); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL idle_again_mode got %0d exp 0", mode); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        tick_1ms   = 1'b0;
        btn_start  = 1'b0;
        btn_react  = 1'b0;
        rand_value = 14'h3064;
        test_reset;
        test_idle_react;
        test_normal_round;
        test_false_start;
        test_tie_arm;
        test_tie_go;
        test_timeout;
        test_reset_mid_round;
        test_full_session;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
